uart_tx_msg_seq: RTL and testbench

Parametrised message sequencer that feeds a fixed ASCII string, byte by byte, into the UART transmitter. For each byte it presents the byte on `o_data` and asserts the transmitter's active-low enable for a programmable number of cycles. It then waits for the transmitter's ready-for-next pulse before sending the next byte. String contents, length, enable-pulse width, single-shot or repeat mode, and the inter-message gap are all configurable. It adds start, busy and done handshakes and a synchronous reset.

---
 rtl/uart_pkg.sv | 18 +
 rtl/tx_en_stretch.sv | 39 +++
 rtl/uart_tx_msg_seq.sv | 136 +++++++++++++
 tb/tb_uart_tx_msg_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART message sequencer
package uart_pkg;

   localparam int UART_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      PULSE,
      WAIT_RFN,
      GAP
   } seq_state_t;

   localparam logic [UART_DATA_W-1:0] ASCII_D = 8'h44;
   localparam logic [UART_DATA_W-1:0] ASCII_O = 8'h4F;
   localparam logic [UART_DATA_W-1:0] ASCII_M = 8'h4D;
   localparam logic [UART_DATA_W-1:0] ASCII_I = 8'h69;

endpackage

// File: rtl/tx_en_stretch.sv
// rtl/tx_en_stretch.sv - fixed-width active-low enable pulse generator
module tx_en_stretch #(
   parameter int PULSE_CYCLES = 2
) (
   input  logic clk,
   input  logic i_rst,
   input  logic i_fire,
   output logic o_nEN,
   output logic o_last
);

   localparam int CNT_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PULSE_CYCLES - 1);

   logic             r_nEN;
   logic [CNT_W-1:0] r_cnt;

   // final low cycle of the pulse; the FSM uses it to pick its next state
   assign o_last = !r_nEN && (r_cnt == CNT_LAST);
   assign o_nEN  = r_nEN;

   // start the pulse on fire, count low cycles, release after the last one
   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_nEN <= 1'b1;
         r_cnt <= '0;
      end else if (i_fire) begin
         r_nEN <= 1'b0;
         r_cnt <= '0;
      end else if (!r_nEN) begin
         if (o_last) begin
            r_nEN <= 1'b1;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_msg_seq.sv
// rtl/uart_tx_msg_seq.sv - feeds a fixed string byte by byte into a UART transmitter
module uart_tx_msg_seq
   import uart_pkg::*;
#(
   parameter int                       MSG_LEN      = 3,
   parameter logic [8*MSG_LEN-1:0]     MSG          = "DOM",
   parameter int                       PULSE_CYCLES = 2,
   parameter int                       REPEAT       = 1,
   parameter int                       GAP_CYCLES   = 0,
   parameter int                       AUTO_START   = 1
) (
   input  logic                   clk,
   input  logic                   i_rst,
   input  logic                   i_start,
   input  logic                   i_RFN,
   output logic [UART_DATA_W-1:0] o_data,
   output logic                   o_nTx_EN,
   output logic                   o_busy,
   output logic                   o_done
);

   localparam int IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_LEN - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   seq_state_t             r_state;
   seq_state_t             w_state_nxt;
   logic [IDX_W-1:0]       r_idx;
   logic [IDX_W-1:0]       w_idx_nxt;
   logic [GAP_W-1:0]       r_gap_cnt;
   logic [UART_DATA_W-1:0] r_data;
   logic                   r_done;
   logic                   w_load;
   logic                   w_done_nxt;
   logic                   w_gap_clr;
   logic                   w_last;
   logic                   w_idx_is_last;

   // byte k is the k-th character from the left of the packed string
   function automatic logic [UART_DATA_W-1:0] msg_byte(input logic [IDX_W-1:0] k);
      msg_byte = '0;
      for (int i = 0; i < MSG_LEN; i++) begin
         if (k == IDX_W'(i)) msg_byte = MSG[8*(MSG_LEN-i)-1 -: 8];
      end
   endfunction

   assign w_idx_is_last = (r_idx == IDX_LAST);

   tx_en_stretch #(
      .PULSE_CYCLES(PULSE_CYCLES)
   ) u_stretch (
      .clk    (clk),
      .i_rst  (i_rst),
      .i_fire (w_load),
      .o_nEN  (o_nTx_EN),
      .o_last (w_last)
   );

   // next state: every byte load also fires the enable pulse
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_load      = 1'b0;
      w_done_nxt  = 1'b0;
      w_gap_clr   = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_start || (AUTO_START != 0)) begin
               w_idx_nxt   = '0;
               w_load      = 1'b1;
               w_state_nxt = PULSE;
            end
         end
         PULSE: begin
            if (w_last) begin
               w_state_nxt = WAIT_RFN;
               if (w_idx_is_last) begin
                  w_done_nxt = 1'b1;
                  if (REPEAT == 0) w_state_nxt = IDLE;
               end
            end
         end
         WAIT_RFN: begin
            if (i_RFN) begin
               if (!w_idx_is_last) begin
                  w_idx_nxt   = r_idx + 1'b1;
                  w_load      = 1'b1;
                  w_state_nxt = PULSE;
               end else if (GAP_CYCLES > 0) begin
                  w_gap_clr   = 1'b1;
                  w_state_nxt = GAP;
               end else begin
                  w_idx_nxt   = '0;
                  w_load      = 1'b1;
                  w_state_nxt = PULSE;
               end
            end
         end
         GAP: begin
            if (r_gap_cnt == GAP_LAST) begin
               w_idx_nxt   = '0;
               w_load      = 1'b1;
               w_state_nxt = PULSE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // state, index, data, done and gap counter registers
   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_state   <= IDLE;
         r_idx     <= '0;
         r_data    <= '0;
         r_done    <= 1'b0;
         r_gap_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_done  <= w_done_nxt;
         if (w_load) r_data <= msg_byte(w_idx_nxt);
         if (w_gap_clr) begin
            r_gap_cnt <= '0;
         end else if (r_state == GAP && r_gap_cnt != GAP_LAST) begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
         end
      end
   end

   assign o_data = r_data;
   assign o_busy = (r_state != IDLE);
   assign o_done = r_done;

endmodule

// File: tb/tb_uart_tx_msg_seq.sv
// tb/tb_uart_tx_msg_seq.sv - scoreboard bench for the UART message sequencer
module tb_uart_tx_msg_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // A: defaults ("DOM", 2-cycle pulse, repeat, auto start, no gap)
   logic       rst_a = 1'b1, start_a = 1'b0, rfn_a = 1'b0;
   logic [7:0] data_a;
   logic       nen_a, busy_a, done_a;
   uart_tx_msg_seq u_a (
      .clk(clk), .i_rst(rst_a), .i_start(start_a), .i_RFN(rfn_a),
      .o_data(data_a), .o_nTx_EN(nen_a), .o_busy(busy_a), .o_done(done_a)
   );

   // B: "HI", single shot, manual start
   logic       rst_b = 1'b1, start_b = 1'b0, rfn_b = 1'b0;
   logic [7:0] data_b;
   logic       nen_b, busy_b, done_b;
   uart_tx_msg_seq #(
      .MSG_LEN(2), .MSG(16'h4849), .PULSE_CYCLES(2), .REPEAT(0), .GAP_CYCLES(0), .AUTO_START(0)
   ) u_b (
      .clk(clk), .i_rst(rst_b), .i_start(start_b), .i_RFN(rfn_b),
      .o_data(data_b), .o_nTx_EN(nen_b), .o_busy(busy_b), .o_done(done_b)
   );

   // C: single byte "i", 4-cycle pulse, repeat with a 5-cycle gap, manual start
   logic       rst_c = 1'b1, start_c = 1'b0, rfn_c = 1'b0;
   logic [7:0] data_c;
   logic       nen_c, busy_c, done_c;
   uart_tx_msg_seq #(
      .MSG_LEN(1), .MSG(8'h69), .PULSE_CYCLES(4), .REPEAT(1), .GAP_CYCLES(5), .AUTO_START(0)
   ) u_c (
      .clk(clk), .i_rst(rst_c), .i_start(start_c), .i_RFN(rfn_c),
      .o_data(data_c), .o_nTx_EN(nen_c), .o_busy(busy_c), .o_done(done_c)
   );

   // expected pulses: bits 7:0 = byte, bit 8 = o_done expected when the pulse ends
   int q_a[$], q_b[$], q_c[$];
   logic prev_a = 1'b1, prev_b = 1'b1, prev_c = 1'b1;
   int len_a, len_b, len_c, cur_a, cur_b, cur_c, e_a, e_b, e_c;

   always @(negedge clk) begin
      if (prev_a && !nen_a) begin len_a = 1; cur_a = data_a; end
      else if (!nen_a) len_a++;
      else if (!prev_a) begin
         if (q_a.size() == 0) check("A_unexpected_pulse", cur_a, -1);
         else begin
            e_a = q_a.pop_front();
            check("A_data", cur_a, e_a & 255);
            check("A_len", len_a, 2);
            check("A_done", int'(done_a), e_a >> 8);
         end
      end else if (done_a) check("A_done_stray", 1, 0);
      prev_a = nen_a;
   end

   always @(negedge clk) begin
      if (prev_b && !nen_b) begin len_b = 1; cur_b = data_b; end
      else if (!nen_b) len_b++;
      else if (!prev_b) begin
         if (q_b.size() == 0) check("B_unexpected_pulse", cur_b, -1);
         else begin
            e_b = q_b.pop_front();
            check("B_data", cur_b, e_b & 255);
            check("B_len", len_b, 2);
            check("B_done", int'(done_b), e_b >> 8);
         end
      end else if (done_b) check("B_done_stray", 1, 0);
      prev_b = nen_b;
   end

   always @(negedge clk) begin
      if (prev_c && !nen_c) begin len_c = 1; cur_c = data_c; end
      else if (!nen_c) len_c++;
      else if (!prev_c) begin
         if (q_c.size() == 0) check("C_unexpected_pulse", cur_c, -1);
         else begin
            e_c = q_c.pop_front();
            check("C_data", cur_c, e_c & 255);
            check("C_len", len_c, 4);
            check("C_done", int'(done_c), e_c >> 8);
         end
      end else if (done_c) check("C_done_stray", 1, 0);
      prev_c = nen_c;
   end

   initial begin
      cyc(3);
      check("A_rst_data", data_a, 8'h00);
      check("A_rst_nen", nen_a, 1);
      check("A_rst_busy", busy_a, 0);
      check("A_rst_done", done_a, 0);
      check("B_rst_data", data_b, 8'h00);
      check("B_rst_busy", busy_b, 0);
      rst_b = 1'b0;
      rst_c = 1'b0;

      // A: auto start, then one byte per accepted RFN
      q_a.push_back(8'h44);
      rst_a = 1'b0;
      cyc(1);
      check("A_auto_data", data_a, 8'h44);
      check("A_auto_nen", nen_a, 0);
      check("A_auto_busy", busy_a, 1);
      cyc(8);
      check("A_wait_nen", nen_a, 1);
      check("A_wait_busy", busy_a, 1);
      q_a.push_back(8'h4F);
      rfn_a = 1'b1; cyc(1); rfn_a = 1'b0; cyc(5);
      q_a.push_back(256 + 8'h4D);
      rfn_a = 1'b1; cyc(1); rfn_a = 1'b0; cyc(5);
      q_a.push_back(8'h44);
      rfn_a = 1'b1; cyc(1); rfn_a = 1'b0; cyc(5);
      // reset during the second low cycle of the 4F pulse
      q_a.push_back(8'h4F);
      rfn_a = 1'b1; cyc(1); rfn_a = 1'b0;
      cyc(1);
      rst_a = 1'b1;
      cyc(1);
      check("A_midrst_nen", nen_a, 1);
      check("A_midrst_data", data_a, 8'h00);
      check("A_midrst_busy", busy_a, 0);
      q_a.push_back(8'h44);
      rst_a = 1'b0;
      cyc(1);
      check("A_restart_data", data_a, 8'h44);
      check("A_restart_nen", nen_a, 0);
      cyc(5);

      // B: start together with reset must not start anything
      rst_b = 1'b1; start_b = 1'b1;
      cyc(1);
      rst_b = 1'b0; start_b = 1'b0;
      cyc(4);
      check("B_rststart_nen", nen_b, 1);
      check("B_rststart_busy", busy_b, 0);
      // B: single shot of "HI"
      q_b.push_back(8'h48);
      start_b = 1'b1; cyc(1); start_b = 1'b0;
      check("B_start_data", data_b, 8'h48);
      check("B_start_nen", nen_b, 0);
      check("B_start_busy", busy_b, 1);
      cyc(1);
      check("B_pulse_end_low", nen_b, 0);
      cyc(1);
      check("B_pulse_released", nen_b, 1);
      check("B_mid_busy", busy_b, 1);
      q_b.push_back(256 + 8'h49);
      rfn_b = 1'b1; cyc(1); rfn_b = 1'b0;
      check("B_rfn_data", data_b, 8'h49);
      check("B_rfn_nen", nen_b, 0);
      cyc(2);
      check("B_done_pulse", done_b, 1);
      check("B_done_busy", busy_b, 0);
      cyc(1);
      check("B_done_once", done_b, 0);
      rfn_b = 1'b1; cyc(1); rfn_b = 1'b0; cyc(6);
      check("B_idle_nen", nen_b, 1);
      check("B_idle_data", data_b, 8'h49);

      // C: start, RFN during the pulse is dropped
      q_c.push_back(256 + 8'h69);
      start_c = 1'b1; cyc(1); start_c = 1'b0;
      rfn_c = 1'b1; cyc(1); rfn_c = 1'b0;
      cyc(5);
      check("C_wait_nen", nen_c, 1);
      check("C_wait_busy", busy_c, 1);
      // accepted RFN, held one more cycle into the gap where it is ignored
      q_c.push_back(256 + 8'h69);
      rfn_c = 1'b1; cyc(1);
      cyc(1); rfn_c = 1'b0;
      cyc(3);
      check("C_gap_nen", nen_c, 1);
      check("C_gap_busy", busy_c, 1);
      check("C_gap_data", data_c, 8'h69);
      cyc(1);
      check("C_gap_end_nen", nen_c, 0);
      check("C_gap_end_data", data_c, 8'h69);
      cyc(6);
      check("C_after_nen", nen_c, 1);

      cyc(2);
      check("A_queue_left", q_a.size(), 0);
      check("B_queue_left", q_b.size(), 0);
      check("C_queue_left", q_c.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
